// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if -- button/debug bus between the board front end and the run controller.
//   Inputs to the controller : run_pulse, step_pulse, halt_pulse, clr_cnt, pc, bp_addr, bp_arm
//   Outputs from controller  : cpu_en, state, cyc_cnt, brk_hit
//   master : the side that drives the pulses and watches the status (board glue / bench)
//   slave  : the run controller itself
interface cpu_run_ctrl_if;
    logic        run_pulse;
    logic        step_pulse;
    logic        halt_pulse;
    logic        clr_cnt;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_arm;
    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] cyc_cnt;
    logic        brk_hit;

    modport master (
        output run_pulse, step_pulse, halt_pulse, clr_cnt, pc, bp_addr, bp_arm,
        input  cpu_en, state, cyc_cnt, brk_hit
    );

    modport slave (
        input  run_pulse, step_pulse, halt_pulse, clr_cnt, pc, bp_addr, bp_arm,
        output cpu_en, state, cyc_cnt, brk_hit
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl -- run/step/halt sequencer producing the pipeline advance enable.
//   Free-runs at one cpu_en every RUN_DIV clocks, issues bursts of STEP_CYCLES enables per
//   step request, or holds the CPU halted. Counts issued enables in cyc_cnt.
// Parameters:
//   RUN_DIV     clk cycles per cpu_en in RUN (>=1)
//   STEP_CYCLES enables issued per step request (>=1)
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active low
//   bus  cpu_run_ctrl_if.slave: pulses/clear/breakpoint in, cpu_en/state/cyc_cnt/brk_hit out
// Configuration:
//   CPU_RUN_CTRL_BRK_EN  when defined, a PC breakpoint halts RUN/STEP and sets brk_hit.
//                        When undefined, pc/bp_addr/bp_arm are ignored and brk_hit is 0.
module cpu_run_ctrl #(
    parameter int unsigned RUN_DIV     = 32'd1_000_000,
    parameter int unsigned STEP_CYCLES = 32'd1
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    localparam logic [31:0] DIV_LAST  = 32'(RUN_DIV - 1);
    localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 1);

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] div_q, div_d;
    logic [31:0] step_q, step_d;
    logic        trap;    // breakpoint forces HALT this cycle
    logic        resume;  // run/step accepted from HALT

`ifdef CPU_RUN_CTRL_BRK_EN
    logic brk_q, brk_d;
    logic mask_q, mask_d;  // suppresses re-trap at the PC we just stopped on

    assign trap = bus.bp_arm && (bus.pc == bus.bp_addr) && !mask_q &&
                  ((state_q == ST_RUN) || (state_q == ST_STEP));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        div_d   = div_q;
        step_d  = step_q;
        resume  = 1'b0;
        // Clear wins over the increment in the same cycle.
        cyc_d   = bus.clr_cnt ? 32'd0 : cyc_q + {31'd0, en_q};

        case (state_q)
            ST_HALT: begin
                if (bus.halt_pulse) begin
                    state_d = ST_HALT;
                end else if (bus.run_pulse) begin
                    state_d = ST_RUN;
                    div_d   = 32'd0;
                    en_d    = (DIV_LAST == 32'd0);
                    resume  = 1'b1;
                end else if (bus.step_pulse) begin
                    state_d = ST_STEP;
                    step_d  = STEP_LAST;  // enables still owed after the first one
                    en_d    = 1'b1;
                    resume  = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.halt_pulse || bus.run_pulse || trap) begin
                    state_d = ST_HALT;
                end else begin
                    div_d = (div_q == DIV_LAST) ? 32'd0 : div_q + 32'd1;
                    // Enable is registered, so raise it for the cycle in which the divider
                    // sits at its last count: first enable lands RUN_DIV cycles after the pulse.
                    en_d  = (div_d == DIV_LAST);
                end
            end
            ST_STEP: begin
                if (bus.halt_pulse || trap || (step_q == 32'd0)) begin
                    state_d = ST_HALT;
                end else begin
                    step_d = step_q - 32'd1;
                    en_d   = 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

`ifdef CPU_RUN_CTRL_BRK_EN
    always_comb begin
        brk_d  = brk_q;
        mask_d = mask_q && !en_q;  // mask lifts once an enable has moved the PC on
        if (resume) begin
            brk_d  = 1'b0;
            mask_d = 1'b1;
        end
        if (trap) brk_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_q  <= 1'b0;
            mask_q <= 1'b0;
        end else begin
            brk_q  <= brk_d;
            mask_q <= mask_d;
        end
    end

    assign bus.brk_hit = brk_q;
`else
    logic unused_brk;
    assign unused_brk  = ^{bus.pc, bus.bp_addr, bus.bp_arm, resume};
    assign bus.brk_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HALT;
            en_q    <= 1'b0;
            cyc_q   <= 32'd0;
            div_q   <= 32'd0;
            step_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cyc_q   <= cyc_d;
            div_q   <= div_d;
            step_q  <= step_d;
        end
    end

    assign bus.cpu_en  = en_q;
    assign bus.state   = state_q;
    assign bus.cyc_cnt = cyc_q;
endmodule
